// File: rtl/load_store_unit_if.sv
// Request/response handshake and 8-byte memory bus of the MEM-stage load/store unit.
// slave = unit side, master = pipeline + memory side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic [63:0] memAddr;
    logic [63:0] writeData;
    logic        memWrite;
    logic        memRead;
    logic [63:0] readData;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, readData,
        output req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
               memAddr, writeData, memWrite, memRead
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, readData,
        input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
               memAddr, writeData, memWrite, memRead
    );
endinterface

// File: rtl/load_store_unit.sv
// RV64I load/store unit: maps sized loads/stores onto a fixed 8-byte memory port,
// with read-modify-write for sub-doubleword stores and sign/zero extension for loads.
module load_store_unit #(
    parameter int MEM_BYTES    = 64,
    parameter bit STRICT_ALIGN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, RMW_WR, SD_WR} state_t;

    state_t      state, state_nxt;
    logic [63:0] addr_q, wdata_q, merge_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic        accept, range_err, align_err, f3_err, req_err;
    logic [64:0] end_addr;
    logic [63:0] load_ext, merge;

    assign accept    = bus.req_valid && bus.req_ready;
    // 65-bit sum so addresses near 2^64 cannot wrap back into range
    assign end_addr  = {1'b0, bus.req_addr} + 65'd7;
    assign range_err = end_addr > 65'(MEM_BYTES - 1);
    assign f3_err    = bus.req_store ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
    assign req_err   = range_err || align_err || f3_err;

    always_comb begin
        align_err = 1'b0;
        case (bus.req_funct3[1:0])
            2'd1:    align_err = bus.req_addr[0];
            2'd2:    align_err = |bus.req_addr[1:0];
            2'd3:    align_err = |bus.req_addr[2:0];
            default: align_err = 1'b0;
        endcase
        if (!STRICT_ALIGN) align_err = 1'b0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && !req_err)
                      state_nxt = !bus.req_store ? LOAD :
                                  (bus.req_funct3[1:0] == 2'b11) ? SD_WR : RMW_RD;
            RMW_RD:  state_nxt = RMW_WR;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory strobes decode purely from state, so async reset kills a write instantly
    always_comb begin
        bus.req_ready = rst_n && (state == IDLE);
        bus.memRead   = (state == LOAD) || (state == RMW_RD);
        bus.memWrite  = (state == RMW_WR) || (state == SD_WR);
        bus.memAddr   = (bus.memRead || bus.memWrite) ? addr_q : 64'd0;
        bus.writeData = (state == SD_WR)  ? wdata_q :
                        (state == RMW_WR) ? merge_q : 64'd0;
    end

    always_comb begin
        load_ext = 64'd0;
        case (f3_q)
            3'b000:  load_ext = {{56{bus.readData[7]}},  bus.readData[7:0]};
            3'b001:  load_ext = {{48{bus.readData[15]}}, bus.readData[15:0]};
            3'b010:  load_ext = {{32{bus.readData[31]}}, bus.readData[31:0]};
            3'b011:  load_ext = bus.readData;
            3'b100:  load_ext = {56'd0, bus.readData[7:0]};
            3'b101:  load_ext = {48'd0, bus.readData[15:0]};
            3'b110:  load_ext = {32'd0, bus.readData[31:0]};
            default: load_ext = 64'd0;
        endcase
    end

    always_comb begin
        merge = bus.readData;
        case (f3_q[1:0])
            2'd0:    merge = {bus.readData[63:8],  wdata_q[7:0]};
            2'd1:    merge = {bus.readData[63:16], wdata_q[15:0]};
            2'd2:    merge = {bus.readData[63:32], wdata_q[31:0]};
            default: merge = bus.readData;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            merge_q <= 64'd0;
            f3_q    <= 3'd0;
            rd_q    <= 5'd0;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                f3_q    <= bus.req_funct3;
                rd_q    <= bus.req_rd;
            end
            if (state == RMW_RD) merge_q <= merge;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 64'd0;
            bus.resp_rd    <= 5'd0;
            bus.resp_err   <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            if (accept && req_err) begin
                bus.resp_valid <= 1'b1;
                bus.resp_err   <= 1'b1;
                bus.resp_rdata <= 64'd0;
                bus.resp_rd    <= bus.req_rd;
            end
            case (state)
                LOAD: begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= load_ext;
                    bus.resp_rd    <= rd_q;
                end
                SD_WR, RMW_WR: begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= 64'd0;
                    bus.resp_rd    <= rd_q;
                end
                default: ;
            endcase
        end
    end
endmodule
